// File: rtl/sap_core.sv
// Single-accumulator CPU core: PC, MAR, IR, A, B, ALU, flags, output register and
// internal RAM, sequenced by a variable-length T-state controller with halt/run control.
module sap_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic                  run,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    output logic                  halted,
    output logic                  zero_flag,
    output logic                  carry_flag,
    output logic [4:0]            t_state
);
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {S_HALT, S_T0, S_T1, S_T2, S_T3, S_T4} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc, mar;
    logic [DATA_WIDTH-1:0] ir, acc, breg;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] mem_rd;
    logic [3:0]            opcode;
    logic [ADDR_WIDTH-1:0] operand;
    logic [DATA_WIDTH:0]   alu_res;
    logic                  is_arith;
    logic                  unused_ir;

    // SUB is A + ~B + 1 so carry out means "no borrow".
    function automatic logic [DATA_WIDTH:0] alu_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b,
                                                    input logic              sub);
        logic [DATA_WIDTH-1:0] b_eff;
        b_eff = sub ? ~b : b;
        return {1'b0, a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, sub};
    endfunction

    assign mem_rd    = mem[mar];
    assign opcode    = ir[DATA_WIDTH-1 -: 4];
    assign operand   = ir[ADDR_WIDTH-1:0];
    assign unused_ir = ^ir;
    assign is_arith  = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign alu_res   = alu_add(acc, breg, opcode == OP_SUB);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) state <= S_HALT;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        halted     = 1'b0;
        t_state    = 5'b00000;
        case (state)
            S_HALT: begin
                halted = 1'b1;
                if (run) state_next = S_T0;
            end
            S_T0: begin
                t_state    = 5'b00001;
                state_next = S_T1;
            end
            S_T1: begin
                t_state    = 5'b00010;
                state_next = S_T2;
            end
            S_T2: begin
                t_state = 5'b00100;
                case (opcode)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB: state_next = S_T3;
                    OP_HLT:                         state_next = S_HALT;
                    default:                        state_next = S_T0;
                endcase
            end
            S_T3: begin
                t_state    = 5'b01000;
                state_next = is_arith ? S_T4 : S_T0;
            end
            S_T4: begin
                t_state    = 5'b10000;
                state_next = S_T0;
            end
            default: state_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            pc         <= '0;
            mar        <= '0;
            ir         <= '0;
            acc        <= '0;
            breg       <= '0;
            data_out   <= '0;
            out_valid  <= 1'b0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_T0: mar <= pc;
                S_T1: begin
                    ir <= mem_rd;
                    pc <= pc + ADDR_WIDTH'(1);
                end
                S_T2: begin
                    case (opcode)
                        OP_LDA, OP_STA, OP_ADD, OP_SUB: mar <= operand;
                        OP_LDI: acc <= DATA_WIDTH'(operand);
                        OP_JMP: pc  <= operand;
                        OP_JZ:  if (zero_flag)  pc <= operand;
                        OP_JC:  if (carry_flag) pc <= operand;
                        OP_OUT: begin
                            data_out  <= acc;
                            out_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_T3: begin
                    if (opcode == OP_LDA) acc  <= mem_rd;
                    else if (is_arith)    breg <= mem_rd;
                end
                S_T4: begin
                    {carry_flag, acc} <= alu_res;
                    zero_flag         <= (alu_res[DATA_WIDTH-1:0] == '0);
                end
                default: ;
            endcase
        end
    end

    // RAM is not reset; the host writes it only while halted, the core only via STA.
    always_ff @(posedge clk) begin
        if (state == S_HALT && prog_we)
            mem[prog_addr] <= prog_data;
        else if (state == S_T3 && opcode == OP_STA)
            mem[mar] <= acc;
    end
endmodule

// File: tb/tb_sap_core.sv
// Self-checking bench for sap_core: directed program table, timing sequences,
// randomized programs against an instruction-level model, and a 12/8 width instance.
module tb_sap_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear_n = 1'b0;
    logic        run8 = 1'b0, we8 = 1'b0;
    logic [3:0]  addr8 = '0;
    logic [7:0]  pdata8 = '0;
    logic [7:0]  dout8;
    logic        ov8, halt8, z8, c8;
    logic [4:0]  ts8;

    logic        run12 = 1'b0, we12 = 1'b0;
    logic [7:0]  addr12 = '0;
    logic [11:0] pdata12 = '0;
    logic [11:0] dout12;
    logic        ov12, halt12, z12, c12;
    logic [4:0]  ts12;

    sap_core u_dut8 (
        .clk(clk), .clear_n(clear_n), .run(run8), .prog_we(we8), .prog_addr(addr8),
        .prog_data(pdata8), .data_out(dout8), .out_valid(ov8), .halted(halt8),
        .zero_flag(z8), .carry_flag(c8), .t_state(ts8)
    );

    sap_core #(.DATA_WIDTH(12), .ADDR_WIDTH(8)) u_dut12 (
        .clk(clk), .clear_n(clear_n), .run(run12), .prog_we(we12), .prog_addr(addr12),
        .prog_data(pdata12), .data_out(dout12), .out_valid(ov12), .halted(halt12),
        .zero_flag(z12), .carry_flag(c12), .t_state(ts12)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  q8[$];
    logic [11:0] q12[$];
    always @(negedge clk) begin
        if (ov8)  q8.push_back(dout8);
        if (ov12) q12.push_back(dout12);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_n = 1'b0; run8 = 1'b0; we8 = 1'b0; run12 = 1'b0; we12 = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
    endtask

    task automatic load8(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk); we8 = 1'b1; addr8 = a; pdata8 = d;
        @(negedge clk); we8 = 1'b0;
    endtask

    task automatic load12(input logic [7:0] a, input logic [11:0] d);
        @(negedge clk); we12 = 1'b1; addr12 = a; pdata12 = d;
        @(negedge clk); we12 = 1'b0;
    endtask

    // Pulse run, then count edges after the sampling edge until halted rises.
    task automatic run_core(input bit wide, input int budget, output int cycles);
        @(negedge clk);
        if (wide) run12 = 1'b1; else run8 = 1'b1;
        @(posedge clk); #1;
        run8 = 1'b0; run12 = 1'b0;
        check("run_start_halted", wide ? halt12 : halt8, 0);
        cycles = 0;
        while (cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
            if (wide ? halt12 : halt8) break;
        end
        n_checks++;
        if (!(wide ? halt12 : halt8)) begin
            n_fail++;
            $display("FAIL run_timeout: still running after %0d cycles, required halted", budget);
        end
    endtask

    typedef struct {
        string            name;
        logic [15:0][7:0] prog;
        int               cycles;
        int               nout;
        logic [7:0]       outv;
        bit               c;
        bit               z;
    } vec_t;
    vec_t vecs[7];

    task automatic w(input int k, input int a, input logic [7:0] d);
        vecs[k].prog[a] = d;
    endtask

    task automatic setv(input int k, input string nm, input int cyc, input int nout,
                        input logic [7:0] o, input bit c, input bit z);
        vecs[k].name = nm; vecs[k].prog = '0; vecs[k].cycles = cyc;
        vecs[k].nout = nout; vecs[k].outv = o; vecs[k].c = c; vecs[k].z = z;
    endtask

    // Instruction-level reference model of the 8/4 core, run from reset state.
    logic [7:0] m_mem [16];
    int         m_outs[$];

    task automatic model_run(output int cycles, output bit c, output bit z);
        int pc, a, b, op, opd;
        bit done;
        pc = 0; a = 0; c = 0; z = 0; cycles = 0; done = 0;
        m_outs.delete();
        for (int n = 0; n < 200 && !done; n++) begin
            op  = int'(m_mem[pc][7:4]);
            opd = int'(m_mem[pc][3:0]);
            pc  = (pc + 1) % 16;
            case (op)
                1:  begin a = m_mem[opd]; cycles += 4; end
                2:  begin b = m_mem[opd]; c = (a + b) > 255; a = (a + b) % 256; z = (a == 0); cycles += 5; end
                3:  begin b = m_mem[opd]; c = (a >= b); a = (a - b + 256) % 256; z = (a == 0); cycles += 5; end
                4:  begin m_mem[opd] = 8'(a); cycles += 4; end
                5:  begin a = opd; cycles += 3; end
                6:  begin pc = opd; cycles += 3; end
                7:  begin if (z) pc = opd; cycles += 3; end
                8:  begin if (c) pc = opd; cycles += 3; end
                14: begin m_outs.push_back(a); cycles += 3; end
                15: begin cycles += 3; done = 1; end
                default: cycles += 3;
            endcase
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, ecyc;
        bit ec, ez;
        int ts_exp[16];
        logic [7:0] prog_copy [16];

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_out", dout8, 0);
        check("rst_out_valid", ov8, 0);
        check("rst_halted", halt8, 1);
        check("rst_zero", z8, 0);
        check("rst_carry", c8, 0);
        check("rst_t_state", ts8, 0);
        check("rst12_halted", halt12, 1);
        check("rst12_data_out", dout12, 0);
        @(negedge clk); clear_n = 1'b1;

        // Directed program table
        setv(0, "add", 15, 1, 8'h08, 0, 0);
        w(0, 0, 8'h1E); w(0, 1, 8'h2F); w(0, 2, 8'hE0); w(0, 3, 8'hF0); w(0, 14, 8'h05); w(0, 15, 8'h03);
        setv(1, "sub_borrow", 14, 1, 8'hFE, 0, 0);
        w(1, 0, 8'h53); w(1, 1, 8'h3F); w(1, 2, 8'hE0); w(1, 3, 8'hF0); w(1, 15, 8'h05);
        setv(2, "sub_zero_jz", 20, 1, 8'h0A, 1, 1);
        w(2, 0, 8'h55); w(2, 1, 8'h3F); w(2, 2, 8'h78); w(2, 3, 8'hE0); w(2, 4, 8'hF0);
        w(2, 8, 8'h5A); w(2, 9, 8'hE0); w(2, 10, 8'hF0); w(2, 15, 8'h05);
        setv(3, "overflow_jc_jz", 24, 1, 8'h01, 1, 1);
        w(3, 0, 8'h1E); w(3, 1, 8'h2F); w(3, 2, 8'h85); w(3, 3, 8'hE0); w(3, 4, 8'hF0); w(3, 5, 8'h51);
        w(3, 6, 8'h79); w(3, 7, 8'hE0); w(3, 8, 8'hF0); w(3, 9, 8'hE0); w(3, 10, 8'hF0);
        w(3, 14, 8'hFF); w(3, 15, 8'h01);
        setv(4, "sta_lda", 20, 1, 8'h09, 0, 0);
        w(4, 0, 8'h59); w(4, 1, 8'h4D); w(4, 2, 8'h50); w(4, 3, 8'h1D); w(4, 4, 8'hE0); w(4, 5, 8'hF0);
        setv(5, "undef_nop", 18, 1, 8'h0C, 0, 0);
        w(5, 0, 8'h5C); w(5, 1, 8'h9F); w(5, 2, 8'hD1); w(5, 3, 8'hB7); w(5, 4, 8'hE0); w(5, 5, 8'hF0);
        setv(6, "two_outs", 15, 2, 8'h02, 0, 0);
        w(6, 0, 8'h51); w(6, 1, 8'hE0); w(6, 2, 8'h52); w(6, 3, 8'hE0); w(6, 4, 8'hF0);

        for (int k = 0; k < 7; k++) begin
            for (int a = 0; a < 16; a++) load8(4'(a), vecs[k].prog[a]);
            do_reset();
            q8.delete();
            run_core(0, 200, cyc);
            check({vecs[k].name, "_cycles"}, cyc, vecs[k].cycles);
            check({vecs[k].name, "_nout"}, q8.size(), vecs[k].nout);
            check({vecs[k].name, "_data_out"}, dout8, vecs[k].outv);
            check({vecs[k].name, "_carry"}, c8, vecs[k].c);
            check({vecs[k].name, "_zero"}, z8, vecs[k].z);
        end

        // Per-cycle t_state / out_valid / halted timing of the add program
        ts_exp = '{1, 2, 4, 8, 1, 2, 4, 8, 16, 1, 2, 4, 1, 2, 4, 0};
        for (int a = 0; a < 16; a++) load8(4'(a), vecs[0].prog[a]);
        do_reset();
        @(negedge clk); run8 = 1'b1;
        @(posedge clk); #1; run8 = 1'b0;
        for (int n = 0; n < 16; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            check($sformatf("tstate_e%0d", n), ts8, ts_exp[n]);
            check($sformatf("out_valid_e%0d", n), ov8, (n == 12));
            check($sformatf("halted_e%0d", n), halt8, (n == 15));
        end
        check("timing_data_out", dout8, 8'h08);

        // PC wrap over 16 NOPs; run held high and prog_we pulses while running
        for (int a = 0; a < 16; a++) load8(4'(a), 8'h00);
        do_reset();
        @(negedge clk); run8 = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 48; n++) begin
            @(posedge clk); #1;
            we8 = 1'b0;
            if (n == 5 || n == 20 || n == 30) begin
                we8 = 1'b1; pdata8 = 8'hF0;
                addr8 = (n == 5) ? 4'd0 : (n == 20) ? 4'd3 : 4'd7;
            end
            if (n == 24) check("wrap_pc_mid", u_dut8.pc, 8);
        end
        we8 = 1'b0;
        check("wrap_pc_48", u_dut8.pc, 0);
        check("wrap_t0_48", ts8, 1);
        check("wrap_not_halted", halt8, 0);
        do_reset();
        @(negedge clk); run8 = 1'b1;
        @(posedge clk); #1; run8 = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("prog_we_ignored", halt8, 0);
        do_reset();

        // Reset during ADD T3, then rerun from preserved RAM
        for (int a = 0; a < 16; a++) load8(4'(a), 8'h00);
        load8(0, 8'h1E); load8(1, 8'hE0); load8(2, 8'h2F); load8(3, 8'hE0); load8(4, 8'hF0);
        load8(14, 8'h05); load8(15, 8'h03);
        do_reset();
        @(negedge clk); run8 = 1'b1;
        @(posedge clk); #1; run8 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midadd_t3", ts8, 8);
        check("midadd_data_out", dout8, 8'h05);
        #2 clear_n = 1'b0;
        #1;
        check("midrst_data_out", dout8, 0);
        check("midrst_halted", halt8, 1);
        check("midrst_t_state", ts8, 0);
        check("midrst_out_valid", ov8, 0);
        check("midrst_flags", {c8, z8}, 0);
        @(negedge clk); clear_n = 1'b1;
        q8.delete();
        run_core(0, 100, cyc);
        check("rerun_cycles", cyc, 18);
        check("rerun_nout", q8.size(), 2);
        check("rerun_data_out", dout8, 8'h08);

        // Randomized programs: forward-only branches, STA confined to 12..15
        for (int t = 0; t < 20; t++) begin
            int kind, fwd, anyv, dat;
            logic [3:0] op, opd;
            for (int i = 0; i < 16; i++) m_mem[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 11; i++) begin
                kind = $urandom_range(0, 9);
                fwd  = $urandom_range(i + 1, 11);
                anyv = $urandom_range(0, 15);
                dat  = $urandom_range(12, 15);
                opd  = 4'(anyv);
                case (kind)
                    0: op = (anyv % 6 == 0) ? 4'h0 : 4'(8 + anyv % 6);
                    1: op = 4'h1;
                    2: op = 4'h2;
                    3: op = 4'h3;
                    4: begin op = 4'h4; opd = 4'(dat); end
                    5: op = 4'h5;
                    6: begin op = 4'h6; opd = 4'(fwd); end
                    7: begin op = 4'h7; opd = 4'(fwd); end
                    8: begin op = 4'h8; opd = 4'(fwd); end
                    default: op = 4'hE;
                endcase
                m_mem[i] = {op, opd};
            end
            m_mem[11] = 8'hF0;
            prog_copy = m_mem;
            for (int a = 0; a < 16; a++) load8(4'(a), prog_copy[a]);
            model_run(ecyc, ec, ez);
            do_reset();
            q8.delete();
            run_core(0, 200, cyc);
            check($sformatf("rand%0d_cycles", t), cyc, ecyc);
            check($sformatf("rand%0d_nout", t), q8.size(), m_outs.size());
            for (int i = 0; i < m_outs.size() && i < q8.size(); i++)
                check($sformatf("rand%0d_out%0d", t, i), q8[i], m_outs[i]);
            check($sformatf("rand%0d_carry", t), c8, ec);
            check($sformatf("rand%0d_zero", t), z8, ez);
        end

        // 12-bit data / 8-bit address instance
        load12(8'h00, 12'h5FF); load12(8'h01, 12'h4C8); load12(8'h02, 12'h2C8);
        load12(8'h03, 12'hE00); load12(8'h04, 12'hF00);
        do_reset();
        q12.delete();
        run_core(1, 200, cyc);
        check("w12_cycles", cyc, 18);
        check("w12_data_out", dout12, 12'h1FE);
        check("w12_carry", c12, 0);
        check("w12_zero", z12, 0);
        check("w12_nout", q12.size(), 1);

        load12(8'h00, 12'h6FC); load12(8'hFC, 12'hF00);
        do_reset();
        run_core(1, 100, cyc);
        check("w12_jmp_hlt_cycles", cyc, 6);
        load12(8'h00, 12'hE00); load12(8'h01, 12'hF00);
        load12(8'hFD, 12'h5AB); load12(8'hFE, 12'h000); load12(8'hFF, 12'h000);
        q12.delete();
        run_core(1, 100, cyc);
        check("w12_wrap_cycles", cyc, 15);
        check("w12_wrap_data_out", dout12, 12'h0AB);
        check("w12_wrap_nout", q12.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
